// File: rtl/regfile_pkg.sv
// Shared constants for the LED controller register file: address map,
// fixed register indices and revision.
package regfile_pkg;

  localparam int unsigned ADDR_STATUS = 0;
  localparam int unsigned ADDR_REV    = 1;
  localparam int unsigned ADDR_BASE   = 2;

  localparam int unsigned T0H      = 0;
  localparam int unsigned T0L      = 1;
  localparam int unsigned T1H      = 2;
  localparam int unsigned T1L      = 3;
  localparam int unsigned CHAN_LEN = 4;
  localparam int unsigned CHAN_CNT = 5;

  // Project revision, reported as {REV_MAJOR, REV_MINOR}.
  localparam logic [3:0] REV_MAJOR = 4'd1;
  localparam logic [3:0] REV_MINOR = 4'd2;

endpackage

// File: rtl/regfile_ptr.sv
// Host access pointer: load, post-increment, and wrap within the writable bank.
module regfile_ptr
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned REG_NUM = 6
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ptr_ld_i,
  input  logic [ADDR_W-1:0] ptr_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] ptr_o
);

  localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(ADDR_BASE);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(ADDR_BASE + REG_NUM - 1);

  logic [ADDR_W-1:0] ptr_d, ptr_q;

  // Bursts past the last writable register cycle back to the first one.
  always_comb begin
    ptr_d = ptr_q;
    if (ptr_ld_i) begin
      ptr_d = ptr_i;
    end else if (step_i) begin
      ptr_d = (ptr_q == LastAddr) ? FirstAddr : ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/regfile_shadow.sv
// Shadowed register file: host writes land in shadow, copied to active only
// while the output engine is idle so timing never changes mid-frame.
module regfile_shadow
  import regfile_pkg::*;
#(
  parameter int unsigned REG_NUM = 6,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned CHAN_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ptr_ld_i,
  input  logic [ADDR_W-1:0] ptr_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              engine_idle_i,
  output logic              pending_o,
  output logic              commit_o,
  output logic [DATA_W-1:0] t0h_time_o,
  output logic [DATA_W:0]   t0s_time_o,
  output logic [DATA_W-1:0] t1h_time_o,
  output logic [DATA_W:0]   t1s_time_o,
  output logic [DATA_W-1:0] chan_len_o,
  output logic [CHAN_W-1:0] chan_cnt_o
);

  logic [ADDR_W-1:0] ptr_q;
  logic              rd_acc, wr_acc, wr_hit, commit;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] shadow_q [REG_NUM];
  logic [DATA_W-1:0] active_q [REG_NUM];
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q, pending_q, commit_q;
  logic [DATA_W:0]   t0s_q, t1s_q;
  logic              unused_active;

  // A pointer load takes the whole cycle; any rd/wr alongside it is dropped.
  assign rd_acc = rd_en_i & ~ptr_ld_i;
  assign wr_acc = wr_en_i & ~ptr_ld_i;
  assign commit = engine_idle_i & pending_q;

  regfile_ptr #(
    .ADDR_W  (ADDR_W),
    .REG_NUM (REG_NUM)
  ) u_ptr (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .ptr_ld_i (ptr_ld_i),
    .ptr_i    (ptr_i),
    .step_i   (rd_acc | wr_acc),
    .ptr_o    (ptr_q)
  );

  always_comb begin
    rd_mux = '0;
    wr_hit = 1'b0;
    if (ptr_q == ADDR_W'(ADDR_STATUS)) begin
      rd_mux = DATA_W'(pending_q);
    end else if (ptr_q == ADDR_W'(ADDR_REV)) begin
      rd_mux = DATA_W'({REV_MAJOR, REV_MINOR});
    end
    for (int unsigned i = 0; i < REG_NUM; i++) begin
      if (ptr_q == ADDR_W'(ADDR_BASE + i)) begin
        rd_mux = shadow_q[i];
        wr_hit = wr_acc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        if (wr_acc && (ptr_q == ADDR_W'(ADDR_BASE + i))) begin
          shadow_q[i] <= wr_data_i;
        end
      end
    end
  end

  // Commit copies the pre-write shadow; a same-edge write is picked up next time.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        active_q[i] <= '0;
      end
    end else if (commit) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        active_q[i] <= shadow_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      pending_q  <= 1'b0;
      commit_q   <= 1'b0;
      t0s_q      <= '0;
      t1s_q      <= '0;
    end else begin
      if (rd_acc) begin
        rd_data_q <= rd_mux;
      end
      rd_valid_q <= rd_acc;
      pending_q  <= wr_hit | (pending_q & ~commit);
      commit_q   <= commit;
      t0s_q      <= {1'b0, active_q[T0H]} + {1'b0, active_q[T0L]};
      t1s_q      <= {1'b0, active_q[T1H]} + {1'b0, active_q[T1L]};
    end
  end

  // Channel count only exposes the low bits; extra GP registers have no output.
  always_comb begin
    unused_active = ^active_q[CHAN_CNT];
    for (int unsigned i = CHAN_CNT + 1; i < REG_NUM; i++) begin
      unused_active = unused_active ^ (^active_q[i]);
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign pending_o  = pending_q;
  assign commit_o   = commit_q;
  assign t0h_time_o = active_q[T0H];
  assign t0s_time_o = t0s_q;
  assign t1h_time_o = active_q[T1H];
  assign t1s_time_o = t1s_q;
  assign chan_len_o = active_q[CHAN_LEN];
  assign chan_cnt_o = active_q[CHAN_CNT][CHAN_W-1:0];

endmodule

// File: tb/tb_regfile_shadow.sv
// Self-checking bench for regfile_shadow: directed scenarios plus random
// traffic, all compared against an array-based behavioural model.
module tb_regfile_shadow;
  import regfile_pkg::*;

  localparam int unsigned REG_NUM = 6;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned CHAN_W  = 4;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              ptr_ld_i = 1'b0;
  logic [ADDR_W-1:0] ptr_i = '0;
  logic              wr_en_i = 1'b0;
  logic [DATA_W-1:0] wr_data_i = '0;
  logic              rd_en_i = 1'b0;
  logic              engine_idle_i = 1'b0;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_valid_o, pending_o, commit_o;
  logic [DATA_W-1:0] t0h_time_o, t1h_time_o, chan_len_o;
  logic [DATA_W:0]   t0s_time_o, t1s_time_o;
  logic [CHAN_W-1:0] chan_cnt_o;

  regfile_shadow #(
    .REG_NUM (REG_NUM),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .CHAN_W  (CHAN_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .ptr_ld_i      (ptr_ld_i),
    .ptr_i         (ptr_i),
    .wr_en_i       (wr_en_i),
    .wr_data_i     (wr_data_i),
    .rd_en_i       (rd_en_i),
    .rd_data_o     (rd_data_o),
    .rd_valid_o    (rd_valid_o),
    .engine_idle_i (engine_idle_i),
    .pending_o     (pending_o),
    .commit_o      (commit_o),
    .t0h_time_o    (t0h_time_o),
    .t0s_time_o    (t0s_time_o),
    .t1h_time_o    (t1h_time_o),
    .t1s_time_o    (t1s_time_o),
    .chan_len_o    (chan_len_o),
    .chan_cnt_o    (chan_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_ptr, m_rd, m_t0s, m_t1s;
  bit m_pend, m_valid, m_commit;
  int m_sh [REG_NUM];
  int m_act [REG_NUM];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_read(input int a);
    if (a == 0) return int'(m_pend);
    if (a == 1) return int'({REV_MAJOR, REV_MINOR});
    if (a >= 2 && a <= REG_NUM + 1) return m_sh[a-2];
    return 0;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_rd = 0; m_t0s = 0; m_t1s = 0;
    m_pend = 0; m_valid = 0; m_commit = 0;
    for (int i = 0; i < REG_NUM; i++) begin
      m_sh[i] = 0;
      m_act[i] = 0;
    end
  endtask

  // One clock edge of the specified behaviour, using pre-edge state throughout.
  task automatic model_edge(input bit ld, input int p, input bit wr, input int wd,
                            input bit rd, input bit idle);
    bit com;
    bit wrote;
    com = idle && m_pend;
    wrote = 0;
    m_t0s = m_act[0] + m_act[1];
    m_t1s = m_act[2] + m_act[3];
    m_commit = com;
    m_valid = 0;
    if (com) for (int i = 0; i < REG_NUM; i++) m_act[i] = m_sh[i];
    if (ld) begin
      m_ptr = p;
    end else begin
      if (rd) begin
        m_rd = model_read(m_ptr);
        m_valid = 1;
      end
      if (wr && m_ptr >= 2 && m_ptr <= REG_NUM + 1) begin
        m_sh[m_ptr-2] = wd;
        wrote = 1;
      end
      if (rd || wr) m_ptr = (m_ptr == REG_NUM + 1) ? 2 : (m_ptr + 1) % (1 << ADDR_W);
    end
    m_pend = wrote ? 1'b1 : (com ? 1'b0 : m_pend);
  endtask

  task automatic check_outputs();
    check("rd_valid", 32'(rd_valid_o), 32'(m_valid));
    check("rd_data", 32'(rd_data_o), 32'(m_rd));
    check("pending", 32'(pending_o), 32'(m_pend));
    check("commit", 32'(commit_o), 32'(m_commit));
    check("t0h", 32'(t0h_time_o), 32'(m_act[0]));
    check("t0s", 32'(t0s_time_o), 32'(m_t0s));
    check("t1h", 32'(t1h_time_o), 32'(m_act[2]));
    check("t1s", 32'(t1s_time_o), 32'(m_t1s));
    check("chan_len", 32'(chan_len_o), 32'(m_act[4]));
    check("chan_cnt", 32'(chan_cnt_o), 32'(m_act[5] % (1 << CHAN_W)));
  endtask

  task automatic check_zero(input string tag);
    logic [31:0] all;
    all = 32'(rd_data_o) | 32'(rd_valid_o) | 32'(pending_o) | 32'(commit_o) |
          32'(t0h_time_o) | 32'(t0s_time_o) | 32'(t1h_time_o) | 32'(t1s_time_o) |
          32'(chan_len_o) | 32'(chan_cnt_o);
    check(tag, all, 32'h0);
  endtask

  task automatic step(input bit ld, input int p, input bit wr, input int wd,
                      input bit rd, input bit idle);
    ptr_ld_i = ld;
    ptr_i = p[ADDR_W-1:0];
    wr_en_i = wr;
    wr_data_i = wd[DATA_W-1:0];
    rd_en_i = rd;
    engine_idle_i = idle;
    @(posedge clk_i);
    model_edge(ld, p, wr, wd, rd, idle);
    #1;
    check_outputs();
  endtask

  initial begin
    int burst [7];
    burst = '{'h10, 'h20, 'h30, 'h40, 'h05, 'h03, 'hAA};
    model_reset();
    #12;
    check_zero("reset_outputs");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Status, revision, shadow[0] from pointer 0
    step(0, 0, 0, 0, 1, 0);
    check("rd_status", 32'(rd_data_o), 32'h00);
    step(0, 0, 0, 0, 1, 0);
    check("rd_rev", 32'(rd_data_o), 32'h12);
    step(0, 0, 0, 0, 1, 0);
    check("rd_shadow0", 32'(rd_data_o), 32'h00);
    step(0, 0, 0, 0, 0, 0);
    check("rd_valid_pulse", 32'(rd_valid_o), 32'h0);

    // Burst of seven wraps back onto reg0 while the engine is busy
    step(1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, burst[i], 0, 0);
    check("busy_pending", 32'(pending_o), 32'h1);
    check("busy_t0h", 32'(t0h_time_o), 32'h00);
    step(0, 0, 0, 0, 0, 1);
    check("commit_pulse", 32'(commit_o), 32'h1);
    check("commit_t0h", 32'(t0h_time_o), 32'hAA);
    check("commit_t1h", 32'(t1h_time_o), 32'h30);
    check("commit_cnt", 32'(chan_cnt_o), 32'h3);
    step(0, 0, 0, 0, 0, 1);
    check("sum_t0s", 32'(t0s_time_o), 32'hCA);
    check("sum_t1s", 32'(t1s_time_o), 32'h70);
    check("commit_once", 32'(commit_o), 32'h0);

    // Sum width boundary
    step(1, 2, 0, 0, 0, 0);
    step(0, 0, 1, 'hFF, 0, 0);
    step(0, 0, 1, 'hFF, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("sum_no_overflow", 32'(t0s_time_o), 32'h1FE);

    // Write on the same edge as a pending commit with idle held high
    step(1, 2, 0, 0, 0, 1);
    step(0, 0, 1, 'h11, 0, 1);
    step(0, 0, 1, 'h22, 0, 1);
    check("overlap_commit", 32'(commit_o), 32'h1);
    check("overlap_pending", 32'(pending_o), 32'h1);
    check("overlap_t0h", 32'(t0h_time_o), 32'h11);
    step(0, 0, 0, 0, 0, 1);
    check("second_commit", 32'(commit_o), 32'h1);
    check("second_pending", 32'(pending_o), 32'h0);
    check("old_sum", 32'(t0s_time_o), 32'h110);
    step(0, 0, 0, 0, 0, 1);
    check("new_sum", 32'(t0s_time_o), 32'h33);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
           bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of a burst
    step(1, 2, 0, 0, 0, 1);
    step(0, 0, 1, 'h5A, 0, 0);
    step(0, 0, 1, 'h6B, 0, 0);
    step(0, 0, 1, 'h7C, 0, 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step(0, 0, 0, 0, 1, 0);
    check("post_reset_status", 32'(rd_data_o), 32'h00);
    step(0, 0, 0, 0, 1, 0);
    check("post_reset_ptr", 32'(rd_data_o), 32'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
